// File: rtl/issue_scheduler.sv
// Reservation-station issue scheduler: wakeup capture, oldest-first select, lowest-FU issue.
// Optional macro ISSUE_SCHEDULER_WAKEUP_BYPASS_EN makes same-cycle woken operands eligible.
module issue_scheduler #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_FU      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  dispatch_valid,
    output logic                  dispatch_ready,
    input  logic [3:0]            dispatch_alu_control,
    input  logic                  dispatch_alu_src,
    input  logic [31:0]           dispatch_imm,
    input  logic [5:0]            dispatch_rs1_tag,
    input  logic [5:0]            dispatch_rs2_tag,
    input  logic                  dispatch_rs1_ready,
    input  logic                  dispatch_rs2_ready,
    input  logic [31:0]           dispatch_rs1_value,
    input  logic [31:0]           dispatch_rs2_value,
    input  logic [5:0]            dispatch_dest_tag,
    input  logic [5:0]            dispatch_rob_index,
    input  logic [NUM_FU-1:0]     wakeup_active,
    input  logic [6*NUM_FU-1:0]   wakeup_tag,
    input  logic [32*NUM_FU-1:0]  wakeup_value,
    input  logic [NUM_FU-1:0]     fu_available,
    output logic [NUM_FU-1:0]     fu_write_enable,
    output logic [3:0]            fu_alu_control,
    output logic                  fu_alu_src,
    output logic [31:0]           fu_imm,
    output logic [31:0]           fu_rs1_value,
    output logic [31:0]           fu_rs2_value,
    output logic [5:0]            fu_tag_to_output,
    output logic [5:0]            fu_rob_index,
    output logic [4:0]            occupancy
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic        r_valid   [NUM_ENTRIES];
    logic [3:0]  r_alu_ctl [NUM_ENTRIES];
    logic        r_alu_src [NUM_ENTRIES];
    logic [31:0] r_imm     [NUM_ENTRIES];
    logic [5:0]  r_rs1_tag [NUM_ENTRIES];
    logic [5:0]  r_rs2_tag [NUM_ENTRIES];
    logic        r_rs1_rdy [NUM_ENTRIES];
    logic        r_rs2_rdy [NUM_ENTRIES];
    logic [31:0] r_rs1_val [NUM_ENTRIES];
    logic [31:0] r_rs2_val [NUM_ENTRIES];
    logic [5:0]  r_dest    [NUM_ENTRIES];
    logic [5:0]  r_rob     [NUM_ENTRIES];
    logic [7:0]  r_age     [NUM_ENTRIES];
    logic [4:0]  r_occ;

    logic        w_rs1_hit [NUM_ENTRIES];
    logic        w_rs2_hit [NUM_ENTRIES];
    logic [31:0] w_rs1_wv  [NUM_ENTRIES];
    logic [31:0] w_rs2_wv  [NUM_ENTRIES];
    logic        w_rs1_ok  [NUM_ENTRIES];
    logic        w_rs2_ok  [NUM_ENTRIES];
    logic [31:0] w_rs1_eff [NUM_ENTRIES];
    logic [31:0] w_rs2_eff [NUM_ENTRIES];
    logic        w_elig    [NUM_ENTRIES];
    logic        w_d1_hit, w_d2_hit;
    logic [31:0] w_d1_wv, w_d2_wv;
    logic        w_found, w_issue, w_free_found, w_disp;
    logic [IW-1:0] w_sel, w_free_idx;
    logic [7:0]  w_best_age;
    logic [NUM_FU-1:0] w_fu_oh;

    // Lanes scanned high to low so the lowest matching lane is the one left standing.
    always_comb begin
        w_d1_hit = 1'b0;
        w_d2_hit = 1'b0;
        w_d1_wv  = '0;
        w_d2_wv  = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            w_rs1_hit[e] = 1'b0;
            w_rs2_hit[e] = 1'b0;
            w_rs1_wv[e]  = '0;
            w_rs2_wv[e]  = '0;
        end
        for (int f = NUM_FU - 1; f >= 0; f--) begin
            if (wakeup_active[f]) begin
                if (wakeup_tag[6*f +: 6] == dispatch_rs1_tag) begin
                    w_d1_hit = 1'b1;
                    w_d1_wv  = wakeup_value[32*f +: 32];
                end
                if (wakeup_tag[6*f +: 6] == dispatch_rs2_tag) begin
                    w_d2_hit = 1'b1;
                    w_d2_wv  = wakeup_value[32*f +: 32];
                end
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (wakeup_tag[6*f +: 6] == r_rs1_tag[e]) begin
                        w_rs1_hit[e] = 1'b1;
                        w_rs1_wv[e]  = wakeup_value[32*f +: 32];
                    end
                    if (wakeup_tag[6*f +: 6] == r_rs2_tag[e]) begin
                        w_rs2_hit[e] = 1'b1;
                        w_rs2_wv[e]  = wakeup_value[32*f +: 32];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
`ifdef ISSUE_SCHEDULER_WAKEUP_BYPASS_EN
            w_rs1_ok[e]  = r_rs1_rdy[e] | w_rs1_hit[e];
            w_rs2_ok[e]  = r_rs2_rdy[e] | w_rs2_hit[e];
            w_rs1_eff[e] = r_rs1_rdy[e] ? r_rs1_val[e] : w_rs1_wv[e];
            w_rs2_eff[e] = r_rs2_rdy[e] ? r_rs2_val[e] : w_rs2_wv[e];
`else
            w_rs1_ok[e]  = r_rs1_rdy[e];
            w_rs2_ok[e]  = r_rs2_rdy[e];
            w_rs1_eff[e] = r_rs1_val[e];
            w_rs2_eff[e] = r_rs2_val[e];
`endif
            w_elig[e] = r_valid[e] & w_rs1_ok[e] & (r_alu_src[e] | w_rs2_ok[e]);
        end
    end

    // Oldest eligible entry; strict '>' keeps the lower index on equal age.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_best_age = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (w_elig[e] && (!w_found || r_age[e] > w_best_age)) begin
                w_found    = 1'b1;
                w_sel      = IW'(e);
                w_best_age = r_age[e];
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (!r_valid[e] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(e);
            end
        end
    end

    assign w_fu_oh         = fu_available & (~fu_available + NUM_FU'(1));
    assign w_issue         = w_found & (|fu_available);
    assign fu_write_enable = w_found ? w_fu_oh : '0;
    assign dispatch_ready  = (r_occ < 5'(NUM_ENTRIES));
    assign w_disp          = dispatch_valid & dispatch_ready & ~flush & w_free_found;
    assign occupancy       = r_occ;

    // Idle bus parks on entry 0's stored fields.
    always_comb begin
        fu_alu_control   = r_alu_ctl[0];
        fu_alu_src       = r_alu_src[0];
        fu_imm           = r_imm[0];
        fu_rs1_value     = r_rs1_val[0];
        fu_rs2_value     = r_rs2_val[0];
        fu_tag_to_output = r_dest[0];
        fu_rob_index     = r_rob[0];
        if (w_issue) begin
            fu_alu_control   = r_alu_ctl[w_sel];
            fu_alu_src       = r_alu_src[w_sel];
            fu_imm           = r_imm[w_sel];
            fu_rs1_value     = w_rs1_eff[w_sel];
            fu_rs2_value     = w_rs2_eff[w_sel];
            fu_tag_to_output = r_dest[w_sel];
            fu_rob_index     = r_rob[w_sel];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                r_valid[e]   <= 1'b0;
                r_alu_ctl[e] <= '0;
                r_alu_src[e] <= 1'b0;
                r_imm[e]     <= '0;
                r_rs1_tag[e] <= '0;
                r_rs2_tag[e] <= '0;
                r_rs1_rdy[e] <= 1'b0;
                r_rs2_rdy[e] <= 1'b0;
                r_rs1_val[e] <= '0;
                r_rs2_val[e] <= '0;
                r_dest[e]    <= '0;
                r_rob[e]     <= '0;
                r_age[e]     <= '0;
            end
        end else if (flush) begin
            r_occ <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++) r_valid[e] <= 1'b0;
        end else begin
            r_occ <= r_occ + 5'(w_disp) - 5'(w_issue);
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (w_disp && w_free_idx == IW'(e)) begin
                    r_valid[e]   <= 1'b1;
                    r_alu_ctl[e] <= dispatch_alu_control;
                    r_alu_src[e] <= dispatch_alu_src;
                    r_imm[e]     <= dispatch_imm;
                    r_rs1_tag[e] <= dispatch_rs1_tag;
                    r_rs2_tag[e] <= dispatch_rs2_tag;
                    r_rs1_rdy[e] <= dispatch_rs1_ready | w_d1_hit;
                    r_rs2_rdy[e] <= dispatch_rs2_ready | w_d2_hit;
                    r_rs1_val[e] <= (!dispatch_rs1_ready && w_d1_hit) ? w_d1_wv : dispatch_rs1_value;
                    r_rs2_val[e] <= (!dispatch_rs2_ready && w_d2_hit) ? w_d2_wv : dispatch_rs2_value;
                    r_dest[e]    <= dispatch_dest_tag;
                    r_rob[e]     <= dispatch_rob_index;
                    r_age[e]     <= '0;
                end else if (r_valid[e]) begin
                    if (w_issue && w_sel == IW'(e)) r_valid[e] <= 1'b0;
                    if (r_age[e] != 8'hFF) r_age[e] <= r_age[e] + 8'd1;
                    if (!r_rs1_rdy[e] && w_rs1_hit[e]) begin
                        r_rs1_rdy[e] <= 1'b1;
                        r_rs1_val[e] <= w_rs1_wv[e];
                    end
                    if (!r_rs2_rdy[e] && w_rs2_hit[e]) begin
                        r_rs2_rdy[e] <= 1'b1;
                        r_rs2_val[e] <= w_rs2_wv[e];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic against a queue-level model.
module tb_issue_scheduler;
    localparam int NE = 8;
    localparam int NF = 2;

    logic clk = 1'b0;
    logic reset, flush, dispatch_valid, dispatch_ready;
    logic [3:0] dispatch_alu_control;
    logic dispatch_alu_src;
    logic [31:0] dispatch_imm, dispatch_rs1_value, dispatch_rs2_value;
    logic [5:0] dispatch_rs1_tag, dispatch_rs2_tag, dispatch_dest_tag, dispatch_rob_index;
    logic dispatch_rs1_ready, dispatch_rs2_ready;
    logic [NF-1:0] wakeup_active, fu_available, fu_write_enable;
    logic [6*NF-1:0] wakeup_tag;
    logic [32*NF-1:0] wakeup_value;
    logic [3:0] fu_alu_control;
    logic fu_alu_src;
    logic [31:0] fu_imm, fu_rs1_value, fu_rs2_value;
    logic [5:0] fu_tag_to_output, fu_rob_index;
    logic [4:0] occupancy;

    issue_scheduler #(.NUM_ENTRIES(NE), .NUM_FU(NF)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_alu_control(dispatch_alu_control), .dispatch_alu_src(dispatch_alu_src),
        .dispatch_imm(dispatch_imm),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
        .dispatch_dest_tag(dispatch_dest_tag), .dispatch_rob_index(dispatch_rob_index),
        .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .fu_available(fu_available), .fu_write_enable(fu_write_enable),
        .fu_alu_control(fu_alu_control), .fu_alu_src(fu_alu_src), .fu_imm(fu_imm),
        .fu_rs1_value(fu_rs1_value), .fu_rs2_value(fu_rs2_value),
        .fu_tag_to_output(fu_tag_to_output), .fu_rob_index(fu_rob_index),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit v; bit [3:0] ctl; bit src; bit [31:0] imm;
        bit [5:0] t1, t2; bit r1, r2; bit [31:0] v1, v2;
        bit [5:0] dest, rob; int age;
    } ent_t;
    ent_t m[NE];

    function automatic void wake(input logic [5:0] tag, output bit hit, output logic [31:0] val);
        hit = 0; val = '0;
        for (int f = 0; f < NF; f++)
            if (!hit && wakeup_active[f] && wakeup_tag[6*f +: 6] == tag) begin
                hit = 1; val = wakeup_value[32*f +: 32];
            end
    endfunction

    `ifdef ISSUE_SCHEDULER_WAKEUP_BYPASS_EN
    localparam bit BYP = 1;
    `else
    localparam bit BYP = 0;
    `endif

    function automatic logic [127:0] entry_bus(input int e, input bit issuing);
        bit h1, h2; logic [31:0] w1, w2, o1, o2;
        wake(m[e].t1, h1, w1);
        wake(m[e].t2, h2, w2);
        o1 = (issuing && BYP && !m[e].r1) ? w1 : m[e].v1;
        o2 = (issuing && BYP && !m[e].r2) ? w2 : m[e].v2;
        return {15'd0, m[e].ctl, m[e].src, m[e].imm, o1, o2, m[e].dest, m[e].rob};
    endfunction

    function automatic int pick();
        int best; bit h1, h2; logic [31:0] w;
        best = -1;
        for (int e = 0; e < NE; e++) begin
            wake(m[e].t1, h1, w);
            wake(m[e].t2, h2, w);
            if (m[e].v && (m[e].r1 || (BYP && h1)) && (m[e].src || m[e].r2 || (BYP && h2)))
                if (best < 0 || m[e].age > m[best].age) best = e;
        end
        return best;
    endfunction

    function automatic int count();
        int c = 0;
        for (int e = 0; e < NE; e++) if (m[e].v) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int e = 0; e < NE; e++) m[e] = '{default: 0};
    endtask

    function automatic logic [127:0] dut_bus();
        return {15'd0, fu_alu_control, fu_alu_src, fu_imm, fu_rs1_value, fu_rs2_value,
                fu_tag_to_output, fu_rob_index};
    endfunction

    // Check outputs against the model, advance the model across one edge, then clear strobes.
    task automatic tick();
        int cnt, sel, fu, fr; bit h; logic [31:0] w; logic [NF-1:0] exp_we; ent_t nx[NE];
        #1;
        cnt = count();
        sel = pick();
        fu  = -1;
        for (int f = 0; f < NF; f++) if (fu_available[f] && fu < 0) fu = f;
        exp_we = (sel >= 0 && fu >= 0) ? NF'(1 << fu) : '0;
        chk("ready", dispatch_ready, cnt < NE);
        chk("occ", occupancy, cnt);
        chk("we", fu_write_enable, exp_we);
        chk("bus", dut_bus(), (exp_we != 0) ? entry_bus(sel, 1) : entry_bus(0, 0));
        nx = m;
        if (flush) begin
            for (int e = 0; e < NE; e++) nx[e].v = 0;
        end else begin
            fr = -1;
            for (int e = 0; e < NE; e++) if (!m[e].v && fr < 0) fr = e;
            for (int e = 0; e < NE; e++) if (m[e].v) begin
                if (exp_we != 0 && e == sel) nx[e].v = 0;
                nx[e].age = (m[e].age < 255) ? m[e].age + 1 : 255;
                wake(m[e].t1, h, w);
                if (!m[e].r1 && h) begin nx[e].r1 = 1; nx[e].v1 = w; end
                wake(m[e].t2, h, w);
                if (!m[e].r2 && h) begin nx[e].r2 = 1; nx[e].v2 = w; end
            end
            if (dispatch_valid && cnt < NE) begin
                nx[fr].v = 1; nx[fr].ctl = dispatch_alu_control; nx[fr].src = dispatch_alu_src;
                nx[fr].imm = dispatch_imm; nx[fr].t1 = dispatch_rs1_tag; nx[fr].t2 = dispatch_rs2_tag;
                nx[fr].dest = dispatch_dest_tag; nx[fr].rob = dispatch_rob_index; nx[fr].age = 0;
                wake(dispatch_rs1_tag, h, w);
                nx[fr].r1 = dispatch_rs1_ready || h;
                nx[fr].v1 = (!dispatch_rs1_ready && h) ? w : dispatch_rs1_value;
                wake(dispatch_rs2_tag, h, w);
                nx[fr].r2 = dispatch_rs2_ready || h;
                nx[fr].v2 = (!dispatch_rs2_ready && h) ? w : dispatch_rs2_value;
            end
        end
        @(posedge clk);
        if (!reset) m = nx;
        @(negedge clk);
        dispatch_valid = 0; flush = 0; wakeup_active = '0;
    endtask

    task automatic disp(input logic [3:0] ctl, input logic src, input logic [31:0] imm,
                        input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                        input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                        input logic [5:0] dest, input logic [5:0] rob);
        dispatch_valid = 1; dispatch_alu_control = ctl; dispatch_alu_src = src; dispatch_imm = imm;
        dispatch_rs1_tag = t1; dispatch_rs1_ready = r1; dispatch_rs1_value = v1;
        dispatch_rs2_tag = t2; dispatch_rs2_ready = r2; dispatch_rs2_value = v2;
        dispatch_dest_tag = dest; dispatch_rob_index = rob;
    endtask

    task automatic drain_to(input int target);
        for (int i = 0; i < 40 && occupancy != 5'(target); i++) tick();
        chk("drain", occupancy, target);
    endtask

    initial begin
        reset = 1; flush = 0; fu_available = '0; wakeup_active = '0;
        wakeup_tag = '0; wakeup_value = '0;
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dispatch_valid = 0;
        model_clear();
        @(negedge clk);
        #1;
        chk("rst_ready", dispatch_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_bus", dut_bus(), 0);
        tick();
        reset = 0;

        // Ready ADD issues one cycle after dispatch.
        fu_available = 2'b01;
        disp(4'd0, 0, 32'd0, 6'd1, 1, 32'd5, 6'd2, 1, 32'd7, 6'd9, 6'd1);
        #1 chk("s1_we_dispcyc", fu_write_enable, 0);
        tick();
        #1;
        chk("s1_we", fu_write_enable, 2'b01);
        chk("s1_rs1", fu_rs1_value, 5);
        chk("s1_rs2", fu_rs2_value, 7);
        chk("s1_tag", fu_tag_to_output, 9);
        tick();

        // Operand woken by lane 1.
        disp(4'd2, 1, 32'h44, 6'd3, 0, 32'hDEAD, 6'd4, 0, 32'd0, 6'd12, 6'd2);
        tick();
        wakeup_active = 2'b10; wakeup_tag = {6'd3, 6'd0}; wakeup_value = {32'h10, 32'h99};
        #1;
`ifdef ISSUE_SCHEDULER_WAKEUP_BYPASS_EN
        chk("s2_we_same", fu_write_enable, 2'b01);
        chk("s2_rs1_same", fu_rs1_value, 32'h10);
        tick();
`else
        chk("s2_we_wake", fu_write_enable, 0);
        tick();
        #1;
        chk("s2_we_next", fu_write_enable, 2'b01);
        chk("s2_rs1_next", fu_rs1_value, 32'h10);
        tick();
`endif
        drain_to(0);

        // Fill all entries with no FU, then release FU1.
        fu_available = 2'b00;
        for (int i = 0; i < NE; i++) begin
            disp(4'(i), 0, 32'(i), 6'd0, 1, 32'(100 + i), 6'd0, 1, 32'(200 + i), 6'(20 + i), 6'(i));
            tick();
        end
        #1;
        chk("s3_ready_full", dispatch_ready, 0);
        chk("s3_occ_full", occupancy, NE);
        disp(4'd15, 0, 32'd0, 6'd0, 1, 32'd0, 6'd0, 1, 32'd0, 6'd0, 6'd63);
        tick();
        fu_available = 2'b10;
        #1;
        chk("s3_we_fu1", fu_write_enable, 2'b10);
        chk("s3_oldest", fu_rob_index, 0);
        tick();
        #1;
        chk("s3_ready_after", dispatch_ready, 1);
        chk("s3_occ_after", occupancy, NE - 1);
        drain_to(0);

        // Older eligible entry at index 5 beats younger index 6.
        fu_available = 2'b00;
        for (int i = 0; i < 5; i++) begin
            disp(4'd1, 1, 32'd0, (i == 4) ? 6'd61 : 6'd60, 0, 32'd0, 6'd0, 0, 32'd0, 6'd30, 6'(40 + i));
            tick();
        end
        disp(4'd3, 0, 32'd0, 6'd0, 1, 32'd55, 6'd0, 1, 32'd66, 6'd31, 6'd5);
        tick();
        disp(4'd4, 0, 32'd0, 6'd0, 1, 32'd77, 6'd0, 1, 32'd88, 6'd32, 6'd6);
        tick();
        fu_available = 2'b01;
        #1 chk("s4_idx5_first", fu_rob_index, 5);
        tick();
        #1 chk("s4_idx6_next", fu_rob_index, 6);
        tick();
        wakeup_active = 2'b01; wakeup_tag = {6'd0, 6'd61}; wakeup_value = {32'd0, 32'h61};
        tick();
        drain_to(4);

        // Flush with a simultaneous dispatch.
        fu_available = 2'b00;
        flush = 1;
        disp(4'd5, 0, 32'd0, 6'd0, 1, 32'd1, 6'd0, 1, 32'd2, 6'd33, 6'd50);
        tick();
        fu_available = 2'b11;
        #1;
        chk("s5_occ_flush", occupancy, 0);
        chk("s5_no_issue", fu_write_enable, 0);
        tick();

        // Equal (saturated) age: lower index wins even though it was allocated later.
        fu_available = 2'b00;
        disp(4'd6, 0, 32'd0, 6'd0, 1, 32'd1, 6'd0, 1, 32'd1, 6'd34, 6'd20);
        tick();
        disp(4'd7, 1, 32'd0, 6'd50, 0, 32'd0, 6'd0, 0, 32'd0, 6'd35, 6'd21);
        tick();
        fu_available = 2'b01;
        #1 chk("s6_first", fu_rob_index, 20);
        tick();
        fu_available = 2'b00;
        disp(4'd8, 0, 32'd0, 6'd0, 1, 32'd3, 6'd0, 1, 32'd3, 6'd36, 6'd22);
        tick();
        wakeup_active = 2'b01; wakeup_tag = {6'd0, 6'd50}; wakeup_value = {32'd0, 32'h50};
        tick();
        for (int i = 0; i < 300; i++) tick();
        fu_available = 2'b01;
        #1 chk("s6_tie_low", fu_rob_index, 22);
        tick();
        #1 chk("s6_tie_next", fu_rob_index, 21);
        tick();

        // Reset mid-stream.
        fu_available = 2'b00;
        for (int i = 0; i < 3; i++) begin
            disp(4'd9, 0, 32'd9, 6'd0, 1, 32'd9, 6'd0, 1, 32'd9, 6'd9, 6'(i));
            tick();
        end
        reset = 1;
        fu_available = 2'b11;
        model_clear();
        #1;
        chk("s7_occ", occupancy, 0);
        chk("s7_ready", dispatch_ready, 1);
        chk("s7_we", fu_write_enable, 0);
        chk("s7_bus", dut_bus(), 0);
        tick();
        reset = 0;
        #1 chk("s7_no_old", fu_write_enable, 0);
        tick();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            fu_available = NF'($urandom);
            if ($urandom_range(0, 1) == 1)
                disp(4'($urandom), 1'($urandom), $urandom, 6'($urandom_range(0, 7)),
                     ($urandom_range(0, 2) == 0), $urandom, 6'($urandom_range(0, 7)),
                     ($urandom_range(0, 2) == 0), $urandom, 6'($urandom), 6'($urandom));
            wakeup_active = NF'($urandom);
            for (int f = 0; f < NF; f++) begin
                wakeup_tag[6*f +: 6]    = 6'($urandom_range(0, 7));
                wakeup_value[32*f +: 32] = $urandom;
            end
            if ($urandom_range(0, 63) == 0) flush = 1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- NUM_ENTRIES, 8, reservation-station entries (2..16).
- NUM_FU, 2, functional units served (1..4).
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- dispatch_valid  in  1  new instruction offered.
- dispatch_ready  out  1  at least one free entry.
- dispatch_alu_control  in  4  ALU opcode.
- dispatch_alu_src  in  1  0 = rs1 op rs2; 1 = rs1 op imm.
- dispatch_imm  in  32  immediate.
- dispatch_rs1_tag, dispatch_rs2_tag  in  6 each  source producer tags.
- dispatch_rs1_ready, dispatch_rs2_ready  in  1 each  source value already valid.
- dispatch_rs1_value, dispatch_rs2_value  in  32 each  source values when ready.
- dispatch_dest_tag  in  6  tag the result will broadcast.
- dispatch_rob_index  in  6  ROB slot.
- wakeup_active  in  NUM_FU  per-FU completion strobe.
- wakeup_tag  in  6*NUM_FU  per-FU result tag, FU i at bits [6i+5:6i].
- wakeup_value  in  32*NUM_FU  per-FU result value.
- fu_available  in  NUM_FU  per-FU is_available.
- fu_write_enable  out  NUM_FU  one-hot issue strobe.
- fu_alu_control  out  4  shared issue bus.
- fu_alu_src  out  1  shared issue bus.
- fu_imm, fu_rs1_value, fu_rs2_value  out  32 each  shared issue bus.
- fu_tag_to_output, fu_rob_index  out  6 each  shared issue bus.
- occupancy  out  5  count of valid entries.

Function
REQ-003 The block SHALL write a dispatch into the lowest-index free entry at a rising edge where dispatch_valid && dispatch_ready; dispatch_valid with dispatch_ready low SHALL be ignored.
REQ-004 dispatch_ready SHALL equal (occupancy < NUM_ENTRIES), derived from registered state only; an entry freed by an issue SHALL NOT be reusable at the same edge.
REQ-005 Each edge, every waiting operand whose tag matches an active wakeup lane SHALL capture that lane's value and become ready; if several lanes match, the lowest lane SHALL win.
REQ-006 A dispatched operand not ready but matching an active wakeup lane in the dispatch cycle SHALL be stored as ready with the wakeup value.
REQ-007 An entry SHALL be eligible when valid and both operands ready; rs2 readiness SHALL be ignored when alu_src = 1.
REQ-008 Each entry SHALL hold an 8-bit age, cleared on allocation and incremented each cycle resident, saturating at 255.
REQ-009 Each cycle at most one instruction SHALL issue: the eligible entry with greatest age (ties to lowest index), sent to the lowest-index FU with fu_available high.
REQ-010 Issue outputs SHALL be combinational from registered state and fu_available; fu_write_enable SHALL be one-hot or zero and zero when no entry is eligible or no FU is available.
REQ-011 When fu_write_enable is zero, the shared issue bus SHALL hold the value of entry 0, whether valid or not.
REQ-012 The issued entry SHALL be freed at the edge ending its issue cycle; minimum dispatch-to-issue latency SHALL be one cycle.
REQ-013 flush SHALL invalidate all entries at the next edge; flush SHALL win over a simultaneous dispatch; issue outputs SHALL still follow REQ-010 during the flush cycle.
REQ-014 occupancy SHALL change by +1, -1, 0 (dispatch and issue in the same cycle) or reset to 0 on flush.

Reset
REQ-015 reset SHALL asynchronously clear all entry valid bits, ages and stored fields to 0; dispatch_ready = 1, occupancy = 0, fu_write_enable = 0, and every issue-bus output = 0 while reset is high and afterward until the first dispatch.
REQ-016 reset asserted mid-operation SHALL discard all pending entries with no issue on the following cycle.

Configuration
REQ-017 Macro ISSUE_SCHEDULER_WAKEUP_BYPASS_EN: when defined, an entry whose last missing operand is woken in the current cycle SHALL be eligible that same cycle, with the operand value muxed from wakeup_value; when undefined, it SHALL become eligible the following cycle (REQ-005 capture only).

Verification
REQ-018 The bench SHALL cover these directed scenarios.
- Reset, then dispatch ADD (ready, 5, 7, dest 9), FU0 available -> fu_write_enable = 01 one cycle later, rs1 = 5, rs2 = 7, tag 9.
- Dispatch entry with rs1 tag 3 not ready; wakeup lane1 tag 3, value 0x10 -> issue with rs1 = 0x10; same cycle with the macro defined, next cycle without it.
- Fill 8 entries with no FU available -> dispatch_ready = 0, occupancy = 8; raise fu_available = 10 -> oldest entry issues to FU1, dispatch_ready = 1 next cycle.
- Two entries eligible, older at index 5 -> index 5 issues first; equal age -> lower index issues.
- Flush with occupancy 4 and a simultaneous dispatch -> occupancy = 0, no issue after the flush edge.
- Assert reset mid-stream -> all outputs at their reset values immediately, no later issue of old entries.
